sync_fifo_ctrl: RTL
===================

Name: sync_fifo_ctrl

Overview:
Controller that turns the team's 1-read-latency dual-port ram block into a synchronous first-word-fall-through FIFO with valid/ready handshakes on both sides.
- Owns write/read pointers, occupancy, full/empty, and the ram port sequencing.
- Hides the ram read latency behind a 2-entry output buffer, so streaming reads sustain 1 word/cycle.
- The ram is instantiated beside it at the FIFO top level; this block drives its we/wa/wd/ra and consumes rd.

Parameters:
DWIDTH, 16, data width; must match the ram.
AWIDTH, 4, ram address width.
DEPTH, 16, ram entries; must equal 2**AWIDTH (elaboration-time check).

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  producer has wr_data
wr_ready  out  1  controller can accept a word
wr_data  in  DWIDTH  write payload
rd_valid  out  1  rd_data is valid
rd_ready  in  1  consumer takes rd_data
rd_data  out  DWIDTH  head-of-FIFO word
count  out  AWIDTH+2  words held: ram + in-flight + output buffer
full  out  1  ram holds DEPTH words
empty  out  1  count == 0
ram_we  out  1  to ram we
ram_wa  out  AWIDTH  to ram wa
ram_wd  out  DWIDTH  to ram wd
ram_ra  out  AWIDTH  to ram ra
ram_rd  in  DWIDTH  from ram rd (valid one cycle after ram_ra is sampled)

Behaviour:
- Reset (async assert, sync release): wptr, rptr = 0; mem_cnt = 0; inflight = 0; output buffer empty.
  - Outputs during and after reset: rd_valid = 0, rd_data = 0, count = 0, empty = 1, full = 0.
  - wr_ready and ram_we are forced 0 while rst_n is low.
  - Reset mid-operation discards all held words and any in-flight read; ram contents are left untouched.
- Write:
  - push = wr_valid && wr_ready, where wr_ready = !full.
  - ram_we = push; ram_wa = wptr[AWIDTH-1:0]; ram_wd = wr_data (combinational pass-through).
  - On push, wptr increments and wraps modulo DEPTH.
- Fetch:
  - fetch = (mem_cnt != 0) && (out_cnt + inflight - pop < 2), where pop = rd_valid && rd_ready.
  - ram_ra = rptr. On fetch, rptr increments (wraps) and inflight <= 1; otherwise inflight <= 0.
- Capture: when inflight is 1, ram_rd is written into the output buffer at the next edge.
  - Entry order is preserved.
  - A capture and a pop in the same cycle are both honoured.
- mem_cnt update: mem_cnt <= mem_cnt + push - fetch. Range 0..DEPTH. full = (mem_cnt == DEPTH).
- Read side:
  - rd_valid = (out_cnt != 0); rd_data = oldest buffer entry.
  - rd_data holds stable while rd_valid && !rd_ready.
- count = mem_cnt + inflight + out_cnt; maximum DEPTH+2.
- Latency: a write accepted at edge E0 into an empty FIFO raises rd_valid after edge E2.
- Simultaneous push and pop when full: the pop frees a buffer slot, so the fetch in that cycle lowers mem_cnt next cycle. wr_ready stays low in the full cycle itself; there is no combinational path from rd_ready to wr_ready.
- Read-during-write hazard: fetch only reads slots counted in the registered mem_cnt, so the ram never reads the address being written in the same cycle.
- Wrap-around: pointers are AWIDTH bits wide. Full/empty derive from mem_cnt, not pointer comparison.

Optional Feature:
SYNC_FIFO_CTRL_WATERMARK_EN
- Defined: adds parameter AFULL_LEVEL (default DEPTH-2) and a registered output almost_full.
  - almost_full = 1 when next-state count >= AFULL_LEVEL.
  - Reset value 0; updates on the same edge as count.
- Undefined: no almost_full port, no parameter, no extra logic.

Decomposition:
- Package sync_fifo_ctrl_pkg:
  - localparam function for count width (AWIDTH+2);
  - out_buf depth constant OBUF_DEPTH = 2;
  - pointer increment/wrap function.
- Sub-module: sync_fifo_obuf, the 2-entry output buffer.
  - Inputs: capture strobe, capture data, pop.
  - Outputs: out_cnt, head data.
- The top controller holds the pointers, mem_cnt, inflight and fetch logic.

Test Plan:
- Reset then idle: rd_valid = 0, empty = 1, count = 0, wr_ready = 1 one cycle after rst_n rises; ram_we never asserted.
- Single word: push 16'hA5A5 at E0 with rd_ready = 0 → rd_valid after E2, rd_data = 16'hA5A5, count = 1; then rd_ready = 1 → empty = 1 next cycle.
- Fill: push 18 words 0..17 with rd_ready = 0 → wr_ready low after 18 accepts; count = 18, full = 1; further wr_valid ignored; drain returns 0..17 in order.
- Streaming: wr_valid = rd_ready = 1 continuously for 40 cycles, incrementing data → after initial latency one word per cycle, no gaps, pointers wrap twice, data sequential.
- Backpressure: random rd_ready (50%) with continuous writes of 200 words → scoreboard exact order; rd_data stable whenever rd_valid && !rd_ready.
- Reset mid-stream: assert rst_n low while count = 7 and inflight = 1 → count = 0, rd_valid = 0 immediately; after release, the next push 16'h1234 is the first word read.

Source files
------------

// File: rtl/sync_fifo_ctrl_pkg.sv
// sync_fifo_ctrl_pkg
//   Shared constants and helpers for the synchronous FWFT FIFO controller.
//   - OBUF_DEPTH : entries in the output buffer that hides the ram read latency
//   - cnt_width  : width of the occupancy counter (ram + in-flight + buffer)
//   - ptr_next   : ram pointer increment with wrap at the ram depth
package sync_fifo_ctrl_pkg;

  localparam int OBUF_DEPTH = 2;

  function automatic int cnt_width(input int awidth);
    return awidth + 2;
  endfunction

  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// sync_fifo_ctrl_if
//   Producer/consumer handshake bundle for the FIFO.
//   master : producer + consumer side (drives wr_valid, wr_data, rd_ready)
//   slave  : FIFO controller side (drives wr_ready, rd_valid, rd_data)
interface sync_fifo_ctrl_if #(
  parameter int DWIDTH = 16
);
  logic              wr_valid;
  logic              wr_ready;
  logic [DWIDTH-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DWIDTH-1:0] rd_data;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/sync_fifo_obuf.sv
// sync_fifo_obuf
//   Two-entry output buffer in front of the FIFO read port. Words captured
//   from the ram are queued in arrival order; head is the oldest entry.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   cap        : capture cap_data this edge
//   cap_data   : word returned by the ram
//   pop        : consumer takes head this edge
//   out_cnt    : entries held (0..OBUF_DEPTH)
//   head       : oldest entry
module sync_fifo_obuf
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int DWIDTH = 16,
  localparam int OCW   = $clog2(OBUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap,
  input  logic [DWIDTH-1:0] cap_data,
  input  logic              pop,
  output logic [OCW-1:0]    out_cnt,
  output logic [DWIDTH-1:0] head
);

  logic [DWIDTH-1:0] ent0;
  logic [DWIDTH-1:0] ent1;
  logic [OCW-1:0]    cnt;

  // The controller never captures into a full buffer, and never pops an
  // empty one, so only the reachable combinations are handled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= '0;
    end else begin
      case ({cap, pop})
        2'b10: begin
          if (cnt == '0) ent0 <= cap_data;
          else           ent1 <= cap_data;
          cnt <= cnt + OCW'(1);
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - OCW'(1);
        end
        2'b11: begin
          // count unchanged; the new word lands behind whatever remains
          if (cnt == OCW'(1)) begin
            ent0 <= cap_data;
          end else begin
            ent0 <= ent1;
            ent1 <= cap_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_cnt = cnt;
  assign head    = ent0;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl
//   Turns a 1-read-latency dual-port ram into a first-word-fall-through FIFO.
//   Owns the ram pointers, ram occupancy (mem_cnt), the single outstanding
//   ram read (inflight) and a 2-entry output buffer so streaming reads run
//   at one word per cycle.
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave)         : wr_valid/wr_ready/wr_data, rd_valid/rd_ready/rd_data
//   count               : words held (ram + in-flight + output buffer)
//   full, empty         : ram holds DEPTH words / count == 0
//   ram_we/wa/wd/ra     : ram write port and read address
//   ram_rd              : ram read data, one cycle after ram_ra is sampled
//   almost_full         : only with SYNC_FIFO_CTRL_WATERMARK_EN defined;
//                         registered, set when next count >= AFULL_LEVEL
module sync_fifo_ctrl
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 4,
  parameter int DEPTH  = 16
`ifdef SYNC_FIFO_CTRL_WATERMARK_EN
  ,
  parameter int AFULL_LEVEL = DEPTH - 2
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  sync_fifo_ctrl_if.slave   bus,
  output logic [AWIDTH+1:0] count,
  output logic              full,
  output logic              empty,
`ifdef SYNC_FIFO_CTRL_WATERMARK_EN
  output logic              almost_full,
`endif
  output logic              ram_we,
  output logic [AWIDTH-1:0] ram_wa,
  output logic [DWIDTH-1:0] ram_wd,
  output logic [AWIDTH-1:0] ram_ra,
  input  logic [DWIDTH-1:0] ram_rd
);

  localparam int CW  = cnt_width(AWIDTH);
  localparam int OCW = $clog2(OBUF_DEPTH + 1);

  if (DEPTH != (1 << AWIDTH)) begin : g_depth_chk
    $error("sync_fifo_ctrl: DEPTH must equal 2**AWIDTH");
  end

  logic [AWIDTH-1:0] wptr;
  logic [AWIDTH-1:0] rptr;
  logic [CW-1:0]     mem_cnt;
  logic              inflight;
  logic [OCW-1:0]    out_cnt;
  logic              push;
  logic              pop;
  logic              fetch;
  logic [2:0]        occ_after;

  // full is purely registered state, so rd_ready never reaches wr_ready
  assign full         = (mem_cnt == CW'(DEPTH));
  assign bus.wr_ready = rst_n & ~full;
  assign push         = bus.wr_valid & bus.wr_ready;
  assign pop          = bus.rd_valid & bus.rd_ready;

  // Buffer occupancy once this cycle's pop and the pending capture settle;
  // a new fetch is only issued if its word is guaranteed a slot.
  assign occ_after = 3'(out_cnt) + 3'(inflight) - 3'(pop);
  // mem_cnt is registered, so the slot fetched was written on an earlier
  // edge and never collides with this cycle's ram write.
  assign fetch     = (mem_cnt != '0) && (occ_after < 3'(OBUF_DEPTH));

  assign ram_we = push;
  assign ram_wa = wptr;
  assign ram_wd = bus.wr_data;
  assign ram_ra = rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      if (push)  wptr <= AWIDTH'(ptr_next(32'(wptr), DEPTH));
      if (fetch) rptr <= AWIDTH'(ptr_next(32'(rptr), DEPTH));
      mem_cnt  <= mem_cnt + CW'(push) - CW'(fetch);
      inflight <= fetch;
    end
  end

  sync_fifo_obuf #(
    .DWIDTH (DWIDTH)
  ) u_obuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .cap      (inflight),
    .cap_data (ram_rd),
    .pop      (pop),
    .out_cnt  (out_cnt),
    .head     (bus.rd_data)
  );

  assign bus.rd_valid = (out_cnt != '0);
  assign count        = mem_cnt + CW'(inflight) + CW'(out_cnt);
  assign empty        = (count == '0);

`ifdef SYNC_FIFO_CTRL_WATERMARK_EN
  // Internal moves (fetch, capture) do not change the total, so the next
  // count depends only on the two handshakes.
  logic [CW-1:0] count_nxt;
  assign count_nxt = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) almost_full <= 1'b0;
    else        almost_full <= (count_nxt >= CW'(AFULL_LEVEL));
  end
`endif

endmodule
